// File: rtl/tis_pkg.sv
// Shared opcode field codes and sequencer state encoding for the TIS-100 node.
package tis_pkg;

  localparam logic [3:0] PC_NEXT = 4'd0;
  localparam logic [3:0] PC_JMP  = 4'd1;
  localparam logic [3:0] PC_JEZ  = 4'd2;
  localparam logic [3:0] PC_JNZ  = 4'd3;
  localparam logic [3:0] PC_JGZ  = 4'd4;
  localparam logic [3:0] PC_JLZ  = 4'd5;
  localparam logic [3:0] PC_JRO  = 4'd6;

  localparam logic [1:0] SRC_CONST = 2'd0;
  localparam logic [1:0] SRC_ACC   = 2'd1;
  localparam logic [1:0] SRC_PORT  = 2'd2;
  localparam logic [1:0] SRC_NIL   = 2'd3;

  localparam logic DST_INT  = 1'b0;
  localparam logic DST_PORT = 1'b1;

  localparam logic [1:0] REG_NONE = 2'd0;
  localparam logic [1:0] REG_ACC  = 2'd1;
  localparam logic [1:0] REG_SAV  = 2'd2;
  localparam logic [1:0] REG_SWP  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_WAIT_IN,
    ST_WAIT_OUT
  } seq_state_e;

endpackage

// File: rtl/tis_node_seq_if.sv
// Blocking input/output port handshake between the node sequencer and its neighbours.
interface tis_node_seq_if #(
  parameter int DATA_W = 11
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_valid;
  logic                     out_ready;

  modport master (
    input  in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

  modport slave (
    output in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );
endinterface

// File: rtl/tis_pc_next.sv
// Combinational next-PC: sequential wrap, conditional/absolute jumps, saturating JRO.
module tis_pc_next
  import tis_pkg::*;
#(
  parameter int PC_W   = 4,
  parameter int DATA_W = 11
) (
  input  logic [PC_W-1:0]          pc_i,
  input  logic [PC_W:0]            prog_len_i,
  input  logic [3:0]               pc_instr_i,
  input  logic signed [DATA_W-1:0] const_val_i,
  input  logic signed [DATA_W-1:0] acc_i,
  input  logic signed [DATA_W-1:0] src_val_i,
  output logic [PC_W-1:0]          pc_next_o
);

  logic [PC_W:0]          inc;
  logic [PC_W:0]          tgt;
  logic [PC_W:0]          lenm1;
  logic signed [DATA_W:0] jro_sum;
  logic signed [DATA_W:0] len_s;
  logic                   take;
  logic                   unused_ok;

  assign unused_ok = ^{const_val_i[DATA_W-1:PC_W], lenm1[PC_W]};

  always_comb begin
    inc     = {1'b0, pc_i} + (PC_W+1)'(1);
    tgt     = {1'b0, const_val_i[PC_W-1:0]};
    lenm1   = prog_len_i - (PC_W+1)'(1);
    // pc is zero-extended, src_val sign-extended, so the sum cannot overflow
    jro_sum = $signed({{(DATA_W-PC_W+1){1'b0}}, pc_i}) + $signed({src_val_i[DATA_W-1], src_val_i});
    len_s   = $signed({{(DATA_W-PC_W){1'b0}}, prog_len_i});

    take = 1'b0;
    case (pc_instr_i)
      PC_JMP:  take = 1'b1;
      PC_JEZ:  take = (acc_i == '0);
      PC_JNZ:  take = (acc_i != '0);
      PC_JGZ:  take = !acc_i[DATA_W-1] && (acc_i != '0);
      PC_JLZ:  take = acc_i[DATA_W-1];
      default: take = 1'b0;
    endcase

    if (pc_instr_i == PC_JRO) begin
      if (jro_sum[DATA_W])        pc_next_o = '0;
      else if (jro_sum >= len_s)  pc_next_o = lenm1[PC_W-1:0];
      else                        pc_next_o = jro_sum[PC_W-1:0];
    end else if (take) begin
      pc_next_o = (tgt >= prog_len_i) ? '0 : tgt[PC_W-1:0];
    end else begin
      pc_next_o = (inc >= prog_len_i) ? '0 : inc[PC_W-1:0];
    end
  end

endmodule

// File: rtl/tis_node_seq.sv
// TIS-100 node execution sequencer: fetch, execute, blocking port waits, commit strobes.
module tis_node_seq
  import tis_pkg::*;
#(
  parameter int PC_W   = 4,
  parameter int DATA_W = 11
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     run,
  input  logic [PC_W:0]            prog_len,
  output logic [PC_W-1:0]          pc,
  output logic                     instr_rd,
  input  logic [3:0]               pc_instr,
  input  logic [1:0]               alu_instr,
  input  logic [1:0]               registers_instr,
  input  logic [1:0]               in_mux_sel,
  input  logic                     out_mux_sel,
  input  logic signed [DATA_W-1:0] const_val,
  input  logic signed [DATA_W-1:0] acc,
  input  logic signed [DATA_W-1:0] src_val,
  tis_node_seq_if.master           port_if,
  output logic                     acc_we,
  output logic                     bak_we,
  output logic                     swap,
  output logic [1:0]               alu_op,
  output logic                     commit
);

  seq_state_e               state_q, state_d;
  logic [PC_W-1:0]          pc_q, pc_d, pc_nxt;
  logic signed [DATA_W-1:0] out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic [1:0]               alu_op_q, alu_op_d;
  logic                     in_ready;
  logic                     src_port;
  logic                     dst_port;

  tis_pc_next #(.PC_W(PC_W), .DATA_W(DATA_W)) u_pc_next (
    .pc_i        (pc_q),
    .prog_len_i  (prog_len),
    .pc_instr_i  (pc_instr),
    .const_val_i (const_val),
    .acc_i       (acc),
    .src_val_i   (src_val),
    .pc_next_o   (pc_nxt)
  );

  assign src_port = (in_mux_sel == SRC_PORT);
  assign dst_port = (out_mux_sel == DST_PORT);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    alu_op_d    = alu_op_q;
    instr_rd    = 1'b0;
    in_ready    = 1'b0;
    commit      = 1'b0;

    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (run) begin
          instr_rd = 1'b1;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC, ST_WAIT_IN: begin
        if (state_q == ST_EXEC) alu_op_d = alu_instr;
        // A port source is consumed before any port destination is offered
        if (src_port && !port_if.in_valid) begin
          state_d = ST_WAIT_IN;
        end else begin
          in_ready = src_port;
          if (dst_port) begin
            out_data_d  = src_val;
            out_valid_d = 1'b1;
            state_d     = ST_WAIT_OUT;
          end else begin
            commit  = 1'b1;
            pc_d    = pc_nxt;
            state_d = ST_FETCH;
          end
        end
      end
      ST_WAIT_OUT: begin
        if (port_if.out_ready) begin
          out_valid_d = 1'b0;
          commit      = 1'b1;
          pc_d        = pc_nxt;
          state_d     = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign acc_we = commit && (registers_instr == REG_ACC);
  assign bak_we = commit && (registers_instr == REG_SAV);
  assign swap   = commit && (registers_instr == REG_SWP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      alu_op_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      alu_op_q    <= alu_op_d;
    end
  end

  assign pc                = pc_q;
  assign alu_op            = alu_op_q;
  assign port_if.in_ready  = in_ready;
  assign port_if.out_data  = out_data_q;
  assign port_if.out_valid = out_valid_q;

endmodule

// File: tb/tb_tis_node_seq.sv
// Bench for tis_node_seq: program RAM model, directed scenarios, then a randomized program.
module tb_tis_node_seq;
  import tis_pkg::*;

  localparam int PC_W   = 4;
  localparam int DATA_W = 11;

  typedef struct packed {
    logic [3:0]  pci;
    logic [1:0]  alu;
    logic [1:0]  rg;
    logic [1:0]  src;
    logic        dst;
    logic [10:0] cval;
  } instr_t;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     run;
  logic [PC_W:0]            prog_len;
  logic [PC_W-1:0]          pc;
  logic                     instr_rd;
  logic signed [DATA_W-1:0] acc;
  logic signed [DATA_W-1:0] src_val;
  logic                     acc_we, bak_we, swap, commit;
  logic [1:0]               alu_op;

  instr_t prog [16];
  instr_t ir;

  int checks   = 0;
  int failures = 0;
  int exp_pc;

  tis_node_seq_if #(.DATA_W(DATA_W)) port_if ();

  tis_node_seq #(.PC_W(PC_W), .DATA_W(DATA_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .run             (run),
    .prog_len        (prog_len),
    .pc              (pc),
    .instr_rd        (instr_rd),
    .pc_instr        (ir.pci),
    .alu_instr       (ir.alu),
    .registers_instr (ir.rg),
    .in_mux_sel      (ir.src),
    .out_mux_sel     (ir.dst),
    .const_val       ($signed(ir.cval)),
    .acc             (acc),
    .src_val         (src_val),
    .port_if         (port_if),
    .acc_we          (acc_we),
    .bak_we          (bak_we),
    .swap            (swap),
    .alu_op          (alu_op),
    .commit          (commit)
  );

  always #5 clk = ~clk;

  // Synchronous program RAM: word at pc appears the cycle after instr_rd
  always @(posedge clk) if (instr_rd) ir <= prog[pc];

  function automatic instr_t mk(logic [3:0] pci, logic [1:0] rg, logic [1:0] src,
                                logic dst, int cval, logic [1:0] alu);
    instr_t i;
    i.pci = pci; i.rg = rg; i.src = src; i.dst = dst; i.alu = alu;
    i.cval = 11'(cval);
    return i;
  endfunction

  // Reference next-PC from the instruction semantics, in plain integer arithmetic
  function automatic int ref_next(int p, instr_t i, int a, int s, int len);
    int  t;
    bit  jump;
    case (i.pci)
      4'd1:    jump = 1'b1;
      4'd2:    jump = (a == 0);
      4'd3:    jump = (a != 0);
      4'd4:    jump = (a > 0);
      4'd5:    jump = (a < 0);
      4'd6: begin
        t = p + s;
        if (t < 0) return 0;
        if (t > len - 1) return len - 1;
        return t;
      end
      default: jump = 1'b0;
    endcase
    if (jump) begin
      t = int'(i.cval) % (1 << PC_W);
      return (t >= len) ? 0 : t;
    end
    t = p + 1;
    return (t >= len) ? 0 : t;
  endfunction

  function automatic int strobes_for(logic [1:0] rg);
    case (rg)
      2'd1:    return 4;
      2'd2:    return 2;
      2'd3:    return 1;
      default: return 0;
    endcase
  endfunction

  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Leaves the DUT at a negedge in FETCH with pc expected at 0
  task automatic do_reset(int len);
    rst_n = 1'b0; run = 1'b1; port_if.in_valid = 1'b0; port_if.out_ready = 1'b0;
    step(); step(); step();
    chk("rst_pc", int'(pc), 0);
    chk("rst_out_valid", int'(port_if.out_valid), 0);
    chk("rst_out_data", int'(port_if.out_data), 0);
    chk("rst_commit", int'(commit), 0);
    chk("rst_alu_op", int'(alu_op), 0);
    prog_len = (PC_W+1)'(len);
    rst_n = 1'b1;
    #1;
    chk("rst_idle_rd", int'(instr_rd), 0);
    step();
    exp_pc = 0;
  endtask

  task automatic run_instr(int a, int s, int in_st, int out_st);
    instr_t i;
    int     es;
    i  = prog[exp_pc];
    es = strobes_for(i.rg);
    acc = DATA_W'(a);
    src_val = DATA_W'(s);
    #1;
    chk("fetch_rd", int'(instr_rd), 1);
    chk("fetch_pc", int'(pc), exp_pc);
    chk("fetch_commit", int'(commit), 0);
    step();
    if (i.src == SRC_PORT) begin
      for (int k = 0; k < in_st; k++) begin
        port_if.in_valid = 1'b0;
        #1;
        chk("in_stall", int'({commit, port_if.in_ready, acc_we, bak_we, swap}), 0);
        step();
      end
      port_if.in_valid = 1'b1;
      #1;
      chk("in_ready", int'(port_if.in_ready), 1);
      chk("in_commit", int'(commit), i.dst ? 0 : 1);
      if (!i.dst) chk("in_strobes", int'({acc_we, bak_we, swap}), es);
      step();
      port_if.in_valid = 1'b0;
    end else begin
      #1;
      chk("exec_commit", int'(commit), i.dst ? 0 : 1);
      if (!i.dst) chk("exec_strobes", int'({acc_we, bak_we, swap}), es);
      step();
    end
    if (i.dst) begin
      for (int k = 0; k < out_st; k++) begin
        port_if.out_ready = 1'b0;
        #1;
        chk("out_valid_hold", int'(port_if.out_valid), 1);
        chk("out_data_hold", int'(port_if.out_data), s);
        chk("out_stall_commit", int'(commit), 0);
        step();
      end
      port_if.out_ready = 1'b1;
      #1;
      chk("out_valid", int'(port_if.out_valid), 1);
      chk("out_data", int'(port_if.out_data), s);
      chk("out_commit", int'(commit), 1);
      chk("out_strobes", int'({acc_we, bak_we, swap}), es);
      step();
      port_if.out_ready = 1'b0;
      #1;
      chk("out_valid_drop", int'(port_if.out_valid), 0);
    end
    chk("alu_op", int'(alu_op), int'(i.alu));
    exp_pc = ref_next(exp_pc, i, a, s, int'(prog_len));
  endtask

  initial begin
    acc = '0; src_val = '0; prog_len = 5'd16;
    port_if.in_valid = 1'b0; port_if.out_ready = 1'b0;
    for (int k = 0; k < 16; k++) prog[k] = mk(PC_NEXT, REG_NONE, SRC_CONST, DST_INT, 0, 2'd0);

    // Sequential wrap with prog_len 3, plus a run-low hold in FETCH
    prog[0] = mk(PC_NEXT, REG_ACC, SRC_CONST, DST_INT, 0, 2'd1);
    prog[1] = mk(PC_NEXT, REG_SAV, SRC_ACC,   DST_INT, 0, 2'd2);
    prog[2] = mk(PC_NEXT, REG_SWP, SRC_NIL,   DST_INT, 0, 2'd3);
    do_reset(3);
    for (int k = 0; k < 3; k++) run_instr(3, 1, 0, 0);
    run = 1'b0;
    #1;
    chk("run_low_rd", int'(instr_rd), 0);
    step();
    chk("run_low_pc", int'(pc), 0);
    chk("run_low_rd2", int'(instr_rd), 0);
    run = 1'b1;
    run_instr(0, 0, 0, 0);

    // Conditional jumps, prog_len 16
    prog[0]  = mk(PC_JEZ, REG_NONE, SRC_CONST, DST_INT, 5,  2'd0);
    prog[5]  = mk(PC_JEZ, REG_NONE, SRC_CONST, DST_INT, 9,  2'd0);
    prog[6]  = mk(PC_JLZ, REG_NONE, SRC_CONST, DST_INT, 2,  2'd0);
    prog[2]  = mk(PC_JGZ, REG_NONE, SRC_CONST, DST_INT, 13, 2'd0);
    prog[13] = mk(PC_JNZ, REG_NONE, SRC_CONST, DST_INT, 3,  2'd0);
    do_reset(16);
    run_instr(0, 0, 0, 0);
    run_instr(-1, 0, 0, 0);
    run_instr(-1, 0, 0, 0);
    run_instr(5, 0, 0, 0);
    run_instr(0, 0, 0, 0);
    run_instr(0, 0, 0, 0);
    run_instr(0, 0, 0, 0);
    chk("wrap16_pc", exp_pc, 0);

    // JRO saturation and out-of-range jump target, prog_len 8
    for (int k = 0; k < 16; k++) prog[k] = mk(PC_NEXT, REG_NONE, SRC_CONST, DST_INT, 0, 2'd0);
    prog[0] = mk(PC_JMP, REG_NONE, SRC_CONST, DST_INT, 6,  2'd0);
    prog[6] = mk(PC_JRO, REG_NONE, SRC_CONST, DST_INT, 0,  2'd0);
    prog[7] = mk(PC_JMP, REG_NONE, SRC_CONST, DST_INT, 12, 2'd0);
    do_reset(8);
    run_instr(0, 0, 0, 0);
    run_instr(0, 100, 0, 0);
    run_instr(0, 0, 0, 0);
    prog[0] = mk(PC_JMP, REG_NONE, SRC_CONST, DST_INT, 1, 2'd0);
    prog[1] = mk(PC_JRO, REG_NONE, SRC_CONST, DST_INT, 0, 2'd0);
    run_instr(0, 0, 0, 0);
    run_instr(0, -50, 0, 0);
    prog[0] = mk(4'hF, REG_NONE, SRC_CONST, DST_INT, 6, 2'd0);
    run_instr(-3, 0, 0, 0);

    // Blocking ports: input stall, output stall, input-then-output
    prog[1] = mk(PC_NEXT, REG_ACC,  SRC_PORT,  DST_INT,  0, 2'd2);
    prog[2] = mk(PC_NEXT, REG_NONE, SRC_CONST, DST_PORT, 0, 2'd1);
    prog[3] = mk(PC_NEXT, REG_NONE, SRC_PORT,  DST_PORT, 0, 2'd3);
    run_instr(0, 9, 4, 0);
    run_instr(0, -7, 0, 3);
    run_instr(0, 321, 1, 2);

    // Reset while an output word is pending
    prog[4] = mk(PC_NEXT, REG_NONE, SRC_ACC, DST_PORT, 0, 2'd0);
    src_val = DATA_W'(-5);
    #1;
    chk("pre_rst_pc", int'(pc), 4);
    step();
    step();
    #1;
    chk("pre_rst_out_valid", int'(port_if.out_valid), 1);
    do_reset(8);

    // Randomized program against the reference model
    begin
      int len;
      len = int'($urandom_range(1, 16));
      for (int k = 0; k < 16; k++)
        prog[k] = mk(4'($urandom_range(0, 8)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), int'($urandom_range(0, 2047)), 2'($urandom_range(0, 3)));
      do_reset(len);
      for (int n = 0; n < 60; n++)
        run_instr(int'($urandom_range(0, 2047)) - 1024, int'($urandom_range(0, 2047)) - 1024,
                  int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
